// File: rtl/out_buffer_if.sv
// AXI4-Stream bundle carrying packed result words from out_buffer to the DMA S2MM channel.
interface out_buffer_if;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tstrb, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/out_buffer.sv
// Result buffer: packs PE-array pixels three per word into RAM, then streams
// the words out as an AXI4-Stream master with tlast on the final word.
module out_buffer #(
    parameter int OUT_NUMBER = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_pixel,
    input  logic        i_pixel_valid,
    input  logic        i_layer_done,
    out_buffer_if.master m_axis,
    output logic        o_busy,
    output logic        o_send_done,
    output logic        o_overflow
);

    localparam int WORDS = OUT_NUMBER / 3;
    localparam int PTR_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_SEND
    } state_t;

    state_t           r_state;
    logic [1:0]       r_byte_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [23:0]      r_word;
    logic [31:0]      r_mem [WORDS];
    logic [31:0]      r_tdata;
    logic             r_tlast;
    logic             r_tvalid;
    logic             r_busy;
    logic             r_send_done;
    logic             r_overflow;

    logic             w_collecting;
    logic             w_full;
    logic             w_pix_acc;
    logic             w_pack_we;
    logic             w_flush_we;
    logic             w_we;
    logic [31:0]      w_wdata;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_last_idx;
    logic             w_handshake;
    logic             w_ren;
    logic             w_final;

    assign w_collecting = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_full       = (r_wr_ptr == PTR_W'(WORDS));
    assign w_pix_acc    = i_pixel_valid && w_collecting && !w_full;
    assign w_pack_we    = w_pix_acc && (r_byte_cnt == 2'd2);
    assign w_flush_we   = (r_state == S_FLUSH) && (r_byte_cnt != 2'd0);
    assign w_we         = w_pack_we || w_flush_we;
    assign w_wdata      = w_flush_we ? {8'h00, r_word} : {8'h00, r_word[23:8], i_pixel};
    assign w_wr_next    = r_wr_ptr + {{(PTR_W-1){1'b0}}, w_we};
    assign w_last_idx   = r_wr_ptr - {{(PTR_W-1){1'b0}}, 1'b1};

    // The read register doubles as the output holding register: it only loads
    // when the current beat is empty or being accepted, so stalls hold tdata.
    assign w_handshake  = r_tvalid && m_axis.tready;
    assign w_ren        = (r_state == S_SEND) && (r_rd_ptr < r_wr_ptr) &&
                          (!r_tvalid || m_axis.tready);
    assign w_final      = w_handshake && r_tlast;

    // NOTE: the buffer array has no reset so it maps onto block RAM; only the
    // pointers decide which words are meaningful.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // NOTE: every register below uses <= so all updates see pre-edge values,
    // and later assignments in the case statement cleanly override defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_word      <= 24'h0;
            r_tdata     <= 32'h0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_send_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_send_done <= 1'b0;
            r_wr_ptr    <= w_wr_next;

            if (i_pixel_valid && !w_pix_acc) begin
                r_overflow <= 1'b1;
            end

            if (w_pix_acc) begin
                case (r_byte_cnt)
                    2'd0: begin
                        r_word     <= {i_pixel, 16'h0000};
                        r_byte_cnt <= 2'd1;
                    end
                    2'd1: begin
                        r_word[15:8] <= i_pixel;
                        r_byte_cnt   <= 2'd2;
                    end
                    default: begin
                        r_word     <= 24'h0;
                        r_byte_cnt <= 2'd0;
                    end
                endcase
            end

            if (w_ren) begin
                r_tdata  <= r_mem[r_rd_ptr];
                r_tlast  <= (r_rd_ptr == w_last_idx);
                r_tvalid <= 1'b1;
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end else if (w_handshake) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_layer_done) begin
                        r_state <= S_FLUSH;
                        r_busy  <= 1'b1;
                    end else if (w_pix_acc) begin
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (i_layer_done) begin
                        r_state <= S_FLUSH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_word     <= 24'h0;
                    r_byte_cnt <= 2'd0;
                    r_rd_ptr   <= '0;
                    if (w_wr_next == '0) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_send_done <= 1'b1;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_final) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_send_done <= 1'b1;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_byte_cnt  <= 2'd0;
                        r_tlast     <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tstrb  = {4{r_tvalid}};
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tvalid = r_tvalid;
    assign o_busy        = r_busy;
    assign o_send_done   = r_send_done;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_out_buffer.sv
// Directed self-checking bench for out_buffer: packing, flush, back-pressure,
// overflow, empty layer and reset during transmission.
module tb_out_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_pixel = 8'h00;
    logic       i_pixel_valid = 1'b0;
    logic       i_layer_done = 1'b0;
    logic       o_busy;
    logic       o_send_done;
    logic       o_overflow;

    out_buffer_if m_axis ();

    out_buffer #(.OUT_NUMBER(3000)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_pixel       (i_pixel),
        .i_pixel_valid (i_pixel_valid),
        .i_layer_done  (i_layer_done),
        .m_axis        (m_axis),
        .o_busy        (o_busy),
        .o_send_done   (o_send_done),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_at  = 0;

    // Monitor on the falling edge: records beats that complete at the next rising edge.
    logic [31:0] q_data [$];
    logic        q_last [$];
    int          q_cyc  [$];
    int          first_valid_cyc = -1;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          stall_err = 0;
    int          stall_cnt = 0;
    int          strb_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (m_axis.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_axis.tvalid && m_axis.tstrb !== 4'hF) strb_err++;
        if (prev_stall && (!m_axis.tvalid || m_axis.tdata !== prev_data ||
                           m_axis.tlast !== prev_last)) stall_err++;
        prev_stall = m_axis.tvalid && !m_axis.tready;
        if (prev_stall) stall_cnt++;
        prev_data = m_axis.tdata;
        prev_last = m_axis.tlast;
        if (m_axis.tvalid && m_axis.tready) begin
            q_data.push_back(m_axis.tdata);
            q_last.push_back(m_axis.tlast);
            q_cyc.push_back(cyc);
        end
        if (o_send_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        first_valid_cyc = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        stall_err = 0;
        stall_cnt = 0;
        strb_err  = 0;
    endtask

    task automatic push_pixel(input logic [7:0] b);
        i_pixel       = b;
        i_pixel_valid = 1'b1;
        tick();
        i_pixel_valid = 1'b0;
    endtask

    task automatic layer_done();
        i_layer_done = 1'b1;
        done_at      = cyc;
        tick();
        i_layer_done = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            tick();
            t++;
        end
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no o_send_done within %0d cycles", name, budget);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || m_axis.tstrb !== 4'h0 ||
            m_axis.tdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_axis: tvalid=%b tlast=%b tstrb=%h tdata=%h, want all 0",
                     m_axis.tvalid, m_axis.tlast, m_axis.tstrb, m_axis.tdata);
        end
        n_checks++;
        if (o_busy !== 1'b0 || o_send_done !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b ovf=%b, want 000",
                     o_busy, o_send_done, o_overflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_pack();
        logic [31:0] exp_d [2] = '{32'h00111213, 32'h00141516};
        logic        exp_l [2] = '{1'b0, 1'b1};
        mon_clear();
        m_axis.tready = 1'b1;
        for (int i = 0; i < 6; i++) push_pixel(8'h11 + 8'(i));
        layer_done();
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_flush: got %b want 1", o_busy);
        end
        wait_done(50, "basic");
        n_checks++;
        if (q_data.size() != 2) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beats want 2", q_data.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== exp_l[k]) begin
                    n_fail++;
                    $display("FAIL basic_beat%0d: got %h/%b want %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], exp_l[k]);
                end
            end
        end
        n_checks++;
        if (first_valid_cyc != done_at + 3) begin
            n_fail++;
            $display("FAIL basic_latency: first tvalid at +%0d want +3", first_valid_cyc - done_at);
        end
        n_checks++;
        if (done_cnt != 1 || strb_err != 0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d strb_err=%0d busy=%b want 1/0/0",
                     done_cnt, strb_err, o_busy);
        end
    endtask

    task automatic test_partial_flush();
        logic [31:0] exp_d [2] = '{32'h00A1A2A3, 32'h00A40000};
        logic        exp_l [2] = '{1'b0, 1'b1};
        mon_clear();
        for (int i = 0; i < 4; i++) push_pixel(8'hA1 + 8'(i));
        layer_done();
        wait_done(50, "partial");
        n_checks++;
        if (q_data.size() != 2) begin
            n_fail++;
            $display("FAIL partial_beats: got %0d beats want 2", q_data.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== exp_l[k]) begin
                    n_fail++;
                    $display("FAIL partial_beat%0d: got %h/%b want %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_d [3] = '{32'h00303132, 32'h00333435, 32'h00363738};
        logic        exp_l [3] = '{1'b0, 1'b0, 1'b1};
        int t;
        mon_clear();
        for (int i = 0; i < 9; i++) push_pixel(8'h30 + 8'(i));
        m_axis.tready = 1'b1;
        layer_done();
        t = 1;
        while (done_cnt == 0 && t < 200) begin
            m_axis.tready = (t % 3 == 0);
            tick();
            t++;
        end
        m_axis.tready = 1'b1;
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL bp_timeout: no o_send_done within 200 cycles");
        end
        repeat (3) tick();
        n_checks++;
        if (q_data.size() != 3) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats want 3", q_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (q_data[k] !== exp_d[k] || q_last[k] !== exp_l[k]) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h/%b want %h/%b",
                             k, q_data[k], q_last[k], exp_d[k], exp_l[k]);
                end
            end
        end
        n_checks++;
        if (stall_err != 0 || stall_cnt == 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_stability: stall_err=%0d stalls=%0d pulses=%0d want 0/>0/1",
                     stall_err, stall_cnt, done_cnt);
        end
    endtask

    task automatic test_overflow_throughput();
        int bad = 0;
        int gaps = 0;
        int lasts = 0;
        logic [31:0] w;
        mon_clear();
        m_axis.tready = 1'b1;
        for (int i = 0; i < 3000; i++) push_pixel(8'(i));
        n_checks++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_capacity: got %b want 0", o_overflow);
        end
        push_pixel(8'hEE);
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %b want 1", o_overflow);
        end
        layer_done();
        wait_done(1200, "full");
        n_checks++;
        if (q_data.size() != 1000) begin
            n_fail++;
            $display("FAIL full_beats: got %0d beats want 1000", q_data.size());
        end else begin
            for (int k = 0; k < 1000; k++) begin
                w = {8'h00, 8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)};
                if (q_data[k] !== w) begin
                    if (bad == 0) $display("first bad beat %0d: got %h want %h", k, q_data[k], w);
                    bad++;
                end
                if (q_cyc[k] != q_cyc[0] + k) gaps++;
                if (q_last[k] === 1'b1) lasts++;
            end
            n_checks++;
            if (bad != 0 || gaps != 0) begin
                n_fail++;
                $display("FAIL full_data: bad=%0d gaps=%0d want 0/0", bad, gaps);
            end
            n_checks++;
            if (lasts != 1 || q_last[999] !== 1'b1) begin
                n_fail++;
                $display("FAIL full_tlast: count=%0d last999=%b want 1/1", lasts, q_last[999]);
            end
        end
    endtask

    task automatic test_empty_layer();
        mon_clear();
        layer_done();
        wait_done(20, "empty");
        n_checks++;
        if (done_cyc != done_at + 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL empty_done: pulse at +%0d count %0d want +2/1", done_cyc - done_at, done_cnt);
        end
        n_checks++;
        if (first_valid_cyc != -1 || q_data.size() != 0) begin
            n_fail++;
            $display("FAIL empty_tvalid: first_valid=%0d beats=%0d want -1/0",
                     first_valid_cyc, q_data.size());
        end
    endtask

    task automatic test_reset_mid_send();
        int t = 0;
        mon_clear();
        m_axis.tready = 1'b1;
        for (int i = 0; i < 15; i++) push_pixel(8'h50 + 8'(i));
        layer_done();
        while (q_data.size() < 2 && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (q_data.size() < 2 || m_axis.tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: beats=%0d tvalid=%b want 2/1", q_data.size(), m_axis.tvalid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || o_busy !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drop: tvalid=%b tlast=%b busy=%b ovf=%b want 0000",
                     m_axis.tvalid, m_axis.tlast, o_busy, o_overflow);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (q_data.size() != 2 || q_data[0] !== 32'h00505152 || q_data[1] !== 32'h00535455) begin
            n_fail++;
            $display("FAIL rst_prefix: beats=%0d want 2 (00505152, 00535455)", q_data.size());
        end
        mon_clear();
        for (int i = 0; i < 3; i++) push_pixel(8'h61 + 8'(i));
        layer_done();
        wait_done(50, "after_rst");
        n_checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h00616263 || q_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_rst_beat: beats=%0d want one 00616263 with tlast", q_data.size());
        end
    endtask

    task automatic test_same_cycle_pixel();
        mon_clear();
        for (int i = 0; i < 3; i++) push_pixel(8'h71 + 8'(i));
        i_pixel       = 8'h74;
        i_pixel_valid = 1'b1;
        layer_done();
        i_pixel_valid = 1'b0;
        wait_done(50, "same_cycle");
        n_checks++;
        if (q_data.size() != 2) begin
            n_fail++;
            $display("FAIL same_cycle_beats: got %0d beats want 2", q_data.size());
        end else begin
            n_checks++;
            if (q_data[0] !== 32'h00717273 || q_last[0] !== 1'b0 ||
                q_data[1] !== 32'h00740000 || q_last[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL same_cycle_data: got %h/%b %h/%b want 00717273/0 00740000/1",
                         q_data[0], q_last[0], q_data[1], q_last[1]);
            end
        end
    endtask

    initial begin
        m_axis.tready = 1'b1;
        test_reset();
        test_basic_pack();
        test_partial_flush();
        test_back_pressure();
        test_overflow_throughput();
        test_empty_layer();
        test_reset_mid_send();
        test_same_cycle_pixel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/out_buffer.md
Name: out_buffer

Overview:
- Result-side counterpart of the accelerator input buffer: collects 8-bit output pixels from the PE array, packs them three per 32-bit word and stores them in block RAM.
- On layer completion it streams the packed words back to the DMA S2MM channel as an AXI4-Stream master, asserting tlast on the final word.
- Byte packing mirrors the input side: first byte in [23:16], second in [15:8], third in [7:0]; [31:24] is zero.

Parameters:
- OUT_NUMBER, 3000, pixel capacity of the result buffer in bytes; must be a multiple of 3.
- WORDS, OUT_NUMBER/3, derived word capacity; not to be overridden independently.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- i_pixel  in  8  result pixel from the PE array.
- i_pixel_valid  in  1  i_pixel is valid this cycle; there is no back-pressure to the PE array.
- i_layer_done  in  1  single-cycle pulse: layer finished, flush and transmit.
- m_axis_tdata  out  32  packed result word.
- m_axis_tstrb  out  4  constant 4'b1111 whenever tvalid is high.
- m_axis_tlast  out  1  high on the final word of the layer.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream accept.
- o_busy  out  1  high in FLUSH and SEND.
- o_send_done  out  1  one-cycle pulse when the final word is accepted.
- o_overflow  out  1  sticky: a pixel was dropped.

Behaviour:
- Reset (asynchronous, all registers): state=IDLE; byte_cnt, wr_ptr, rd_ptr, shift register = 0; all outputs 0. A reset during SEND drops tvalid immediately, with no tlast. Buffer RAM contents are not reset.
- States:
  - IDLE -> COLLECT on the first accepted pixel.
  - IDLE or COLLECT -> FLUSH on i_layer_done.
  - FLUSH -> SEND, or -> IDLE with an o_send_done pulse if wr_ptr==0 after the flush.
  - SEND -> IDLE on the final handshake.
- Packing: byte_cnt counts 0..2. Byte0 goes to [23:16], byte1 to [15:8], byte2 to [7:0]. When byte_cnt==2 and a pixel is accepted, {8'h00, word} is written to buf[wr_ptr], wr_ptr increments and byte_cnt returns to 0.
- FLUSH (1 cycle): if byte_cnt!=0, the partial word is written with unfilled low bytes zero, wr_ptr increments and byte_cnt clears.
- Same-cycle i_pixel_valid and i_layer_done in IDLE or COLLECT: the pixel is accepted first and is included in the flushed data.
- Drop rules, each sets o_overflow:
  - a pixel arriving in FLUSH or SEND is dropped;
  - a pixel arriving when wr_ptr==WORDS is dropped.
  - o_overflow clears only on rst.
- i_layer_done in FLUSH or SEND is ignored.
- SEND:
  - Words 0..wr_ptr-1 are sent in order.
  - RAM read latency is 1 cycle. A prefetch/skid register is required so that, with tready held high, one word is transferred per clock with no bubbles.
  - AXI rules: once tvalid rises, tdata and tlast hold until tready; tvalid never depends combinationally on tready.
  - tlast=1 exactly when the word index equals wr_ptr-1.
- Latency: i_layer_done in cycle N gives FLUSH in N+1, SEND in N+2, and the first tvalid in N+3.
- Done: on the tlast handshake, tvalid drops next cycle, o_send_done pulses for 1 cycle, and wr_ptr, rd_ptr, byte_cnt clear. State returns to IDLE, ready for the next layer.
- Pointers are wide enough for WORDS and never wrap; the full condition is wr_ptr==WORDS.

Test Plan:
- Basic pack: 6 pixels 0x11..0x16, then i_layer_done, tready=1 -> exactly 2 beats: 0x00111213, then 0x00141516 with tlast=1; tstrb=4'hF on both; first tvalid 3 cycles after i_layer_done; o_send_done pulses once.
- Partial flush: 4 pixels 0xA1..0xA4, then i_layer_done -> beat 0x00A1A2A3, then 0x00A40000 with tlast=1.
- Back-pressure: 9 pixels, tready toggling 1,0,0,1,... -> 3 beats in order; tdata and tlast stable while tready is low; no duplicated or lost beats.
- Full throughput and overflow: 3001 pixels, then flush with tready=1 -> o_overflow=1; 1000 beats on consecutive cycles; tlast only on beat 999.
- Empty layer: i_layer_done with no pixels -> tvalid never rises; o_send_done pulses in cycle N+2.
- Edge cases:
  - rst asserted mid-SEND after 2 of 5 beats -> tvalid goes 0 immediately.
  - A new layer of 3 pixels is then sent as 1 beat with tlast.
  - A pixel asserted together with i_layer_done is included in the output.
